// File: rtl/ifu_pc_fetch.sv
// PC register and single-outstanding instruction-fetch sequencer for the multicycle NPC core.
// Fetches a doubleword at pc & ~7, hands the selected 32-bit word to decode, then waits for commit.
module ifu_pc_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [63:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [63:0]      imem_rdata,
    input  logic             imem_rerr,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst,
    output logic [63:0]      cpupc,
    input  logic             dnpc_valid,
    input  logic [63:0]      dnpc,
    output logic             fetch_err,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_EXEC,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [63:0]      cpupc_q, cpupc_d;
    logic [31:0]      inst_q, inst_d;
    logic             inst_valid_q, inst_valid_d;
    logic             imem_req_q, imem_req_d;
    logic             fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0]      rdata_word;

    assign rdata_word = cpupc_q[2] ? imem_rdata[63:32] : imem_rdata[31:0];

    always_comb begin
        state_d      = state_q;
        cpupc_d      = cpupc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        imem_req_d   = imem_req_q;
        fetch_err_d  = fetch_err_q;
        fetch_cnt_d  = fetch_cnt_q;
        case (state_q)
            S_REQ: begin
                // First REQ cycle after reset only raises the request; anything
                // arriving from the memory in that cycle belongs to a dead fetch.
                if (!imem_req_q) begin
                    imem_req_d = 1'b1;
                end else if (imem_gnt) begin
                    imem_req_d = 1'b0;
                    if (imem_rvalid && imem_rerr) begin
                        fetch_err_d = 1'b1;
                        state_d     = S_ERR;
                    end else if (imem_rvalid) begin
                        inst_d       = rdata_word;
                        inst_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (imem_rvalid && imem_rerr) begin
                    fetch_err_d = 1'b1;
                    state_d     = S_ERR;
                end else if (imem_rvalid) begin
                    inst_d       = rdata_word;
                    inst_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    inst_valid_d = 1'b0;
                    fetch_cnt_d  = fetch_cnt_q + CNT_W'(1);
                    state_d      = S_EXEC;
                end
            end
            S_EXEC: begin
                // Going straight back to REQ with the request already raised
                // keeps commit-to-valid at two cycles.
                if (dnpc_valid) begin
                    if (dnpc[1:0] == 2'b00) begin
                        cpupc_d    = dnpc;
                        imem_req_d = 1'b1;
                        state_d    = S_REQ;
                    end else begin
                        fetch_err_d = 1'b1;
                        state_d     = S_ERR;
                    end
                end
            end
            default: begin
                imem_req_d   = 1'b0;
                inst_valid_d = 1'b0;
                state_d      = S_ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            cpupc_q      <= RESET_PC;
            inst_q       <= 32'h0;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b0;
            fetch_err_q  <= 1'b0;
            fetch_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cpupc_q      <= cpupc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            imem_req_q   <= imem_req_d;
            fetch_err_q  <= fetch_err_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = {cpupc_q[63:3], 3'b000};
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign cpupc      = cpupc_q;
    assign fetch_err  = fetch_err_q;
    assign fetch_cnt  = fetch_cnt_q;

endmodule

// File: tb/tb_ifu_pc_fetch.sv
// Bench for ifu_pc_fetch: directed scenarios, then random memory/decode/commit traffic
// checked against a transaction-phase reference model.
module tb_ifu_pc_fetch;

    localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [63:0] imem_rdata = 64'h0;
    logic        imem_rerr = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [63:0] cpupc;
    logic        dnpc_valid = 1'b0;
    logic [63:0] dnpc = 64'h0;
    logic        fetch_err;
    logic [63:0] fetch_cnt;

    int total = 0;
    int bad   = 0;

    ifu_pc_fetch #(.RESET_PC(RST_PC), .CNT_W(64)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_rerr(imem_rerr),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .cpupc(cpupc),
        .dnpc_valid(dnpc_valid), .dnpc(dnpc), .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rerr = 1'b0;
        inst_ready = 1'b0; dnpc_valid = 1'b0;
    endtask

    function automatic logic [63:0] mem_dw(input logic [63:0] a);
        return {a[31:0] ^ 32'h1357_9bdf, a[31:0] + 32'h0bad_f00d};
    endfunction

    // reference model state
    logic [63:0] mpc;
    logic [63:0] mcnt;
    logic [31:0] mexp;
    int          ph;   // 0 fetch issued, 1 awaiting data, 2 offered to decode, 3 executing
    logic [63:0] dw;

    initial begin
        #1;
        // ---------------- reset values ----------------
        idle_inputs(); rst = 1'b1;
        step(); step();
        check_eq("rst_req", imem_req, 0);
        check_eq("rst_vld", inst_valid, 0);
        check_eq("rst_pc", cpupc, RST_PC);
        check_eq("rst_inst", inst, 0);
        check_eq("rst_err", fetch_err, 0);
        check_eq("rst_cnt", fetch_cnt, 0);
        rst = 1'b0;
        step();
        check_eq("req_rise", imem_req, 1);
        check_eq("addr0", imem_addr, 64'h8000_0000);
        step();
        check_eq("req_hold", imem_req, 1);
        check_eq("addr_hold", imem_addr, 64'h8000_0000);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check_eq("wait_req", imem_req, 0);
        step();
        imem_rvalid = 1'b1; imem_rdata = 64'h0000_0013_0010_0093;
        step();
        imem_rvalid = 1'b0;
        check_eq("f1_vld", inst_valid, 1);
        check_eq("f1_inst", inst, 32'h0010_0093);
        check_eq("f1_pc", cpupc, 64'h8000_0000);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check_eq("f1_drop", inst_valid, 0);
        check_eq("f1_cnt", fetch_cnt, 1);
        // ---------------- commit to upper word, same-cycle gnt+rvalid ----------------
        dnpc_valid = 1'b1; dnpc = 64'h8000_0004;
        step();
        dnpc_valid = 1'b0;
        check_eq("f2_req", imem_req, 1);
        check_eq("f2_addr", imem_addr, 64'h8000_0000);
        check_eq("f2_pc", cpupc, 64'h8000_0004);
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 64'h0000_0013_0010_0093;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        check_eq("f2_vld", inst_valid, 1);
        check_eq("f2_inst", inst, 32'h0000_0013);
        // ---------------- backpressure, stray commit in HOLD ----------------
        for (int i = 0; i < 5; i++) begin
            dnpc_valid = (i == 2); dnpc = 64'h8000_1000;
            step();
            check_eq("bp_vld", inst_valid, 1);
            check_eq("bp_inst", inst, 32'h0000_0013);
            check_eq("bp_cnt", fetch_cnt, 1);
            check_eq("bp_pc", cpupc, 64'h8000_0004);
        end
        dnpc_valid = 1'b0;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        check_eq("f2_cnt", fetch_cnt, 2);
        check_eq("f2_pc_kept", cpupc, 64'h8000_0004);
        dnpc_valid = 1'b1; dnpc = 64'h8000_0100;
        step();
        dnpc_valid = 1'b0;
        check_eq("f3_addr", imem_addr, 64'h8000_0100);
        check_eq("f3_req", imem_req, 1);
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 64'h1111_2222_3333_4444;
        step();
        imem_gnt = 1'b0; imem_rvalid = 1'b0;
        check_eq("f3_inst", inst, 32'h3333_4444);
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        // ---------------- misaligned commit ----------------
        dnpc_valid = 1'b1; dnpc = 64'h8000_0006;
        step();
        dnpc_valid = 1'b0;
        check_eq("mis_err", fetch_err, 1);
        check_eq("mis_pc", cpupc, 64'h8000_0100);
        for (int i = 0; i < 3; i++) begin
            imem_gnt = 1'b1;
            step();
            check_eq("mis_req", imem_req, 0);
            check_eq("mis_vld", inst_valid, 0);
        end
        imem_gnt = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rec_pc", cpupc, RST_PC);
        check_eq("rec_err", fetch_err, 0);
        // ---------------- access fault in WAIT ----------------
        step();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rerr = 1'b1;
        step();
        imem_rvalid = 1'b0; imem_rerr = 1'b0;
        check_eq("rerr_err", fetch_err, 1);
        check_eq("rerr_vld", inst_valid, 0);
        step();
        check_eq("rerr_req", imem_req, 0);
        // ---------------- reset with grant outstanding, stray rvalid ----------------
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 64'hdead_beef_dead_beef;
        step();
        imem_rvalid = 1'b0;
        check_eq("late_vld", inst_valid, 0);
        check_eq("late_inst", inst, 0);
        check_eq("late_req", imem_req, 1);
        check_eq("late_addr", imem_addr, RST_PC);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 64'h0000_00aa_0000_00bb;
        step();
        imem_rvalid = 1'b0;
        check_eq("late_fetch", inst, 32'h0000_00bb);
        // ---------------- random traffic vs reference model ----------------
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        mpc = RST_PC; mcnt = 0; mexp = 0; ph = 0;
        for (int c = 0; c < 3000; c++) begin
            check_eq("r_req", imem_req, (ph == 0) ? 64'd1 : 64'd0);
            check_eq("r_vld", inst_valid, (ph == 2) ? 64'd1 : 64'd0);
            check_eq("r_cnt", fetch_cnt, mcnt);
            check_eq("r_pc", cpupc, mpc);
            check_eq("r_err", fetch_err, 0);
            idle_inputs();
            imem_rdata = {$urandom, $urandom};
            inst_ready = 1'($urandom_range(0, 1));
            dnpc = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_fffc)};
            dw = mem_dw(mpc);
            case (ph)
                0: begin
                    if ($urandom_range(0, 2) == 0) begin
                        check_eq("r_addr", imem_addr, {mpc[63:3], 3'b000});
                        imem_gnt = 1'b1;
                        if ($urandom_range(0, 1) == 1) begin
                            imem_rvalid = 1'b1; imem_rdata = dw;
                            mexp = mpc[2] ? dw[63:32] : dw[31:0];
                            ph = 2;
                        end else begin
                            ph = 1;
                        end
                    end else begin
                        imem_rvalid = ($urandom_range(0, 3) == 0);
                        dnpc_valid  = ($urandom_range(0, 3) == 0);
                    end
                end
                1: begin
                    if ($urandom_range(0, 2) == 0) begin
                        imem_rvalid = 1'b1; imem_rdata = dw;
                        mexp = mpc[2] ? dw[63:32] : dw[31:0];
                        ph = 2;
                    end
                    dnpc_valid = ($urandom_range(0, 4) == 0);
                end
                2: begin
                    if (inst_ready) begin
                        check_eq("r_inst", inst, mexp);
                        mcnt = mcnt + 1;
                        ph = 3;
                    end
                    imem_rvalid = ($urandom_range(0, 3) == 0);
                    dnpc_valid  = ($urandom_range(0, 4) == 0);
                end
                default: begin
                    if ($urandom_range(0, 2) == 0) begin
                        dnpc_valid = 1'b1;
                        mpc = dnpc;
                        ph = 0;
                    end else begin
                        imem_rvalid = ($urandom_range(0, 3) == 0);
                    end
                end
            endcase
            step();
        end
        idle_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ifu_pc_fetch.md
Name: ifu_pc_fetch

Overview:
- Program-counter register and instruction-fetch sequencer for the multicycle NPC core.
- Holds the architectural PC and issues a fetch to instruction memory.
- Hands the 32-bit instruction to decode over a valid/ready handshake.
- After commit, loads the next PC produced by the next-PC selection stage (dnpc_jump_data) and starts the next fetch.

Parameters:
- RESET_PC, 64'h0000_0000_8000_0000, PC value loaded on reset.
- CNT_W, 64, width of the retired-fetch counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  64  fetch address; 8-byte aligned (pc & ~7).
- imem_gnt  input  1  memory accepted the request this cycle.
- imem_rvalid  input  1  read data valid.
- imem_rdata  input  64  read data, doubleword.
- imem_rerr  input  1  access fault, qualified by imem_rvalid.
- inst_valid  output  1  instruction available to decode.
- inst_ready  input  1  decode accepts the instruction.
- inst  output  32  fetched instruction.
- cpupc  output  64  PC of the current instruction.
- dnpc_valid  input  1  commit pulse: the current instruction retires.
- dnpc  input  64  next PC from next-PC stage, sampled with dnpc_valid.
- fetch_err  output  1  sticky fault indication (misaligned dnpc or imem_rerr).
- fetch_cnt  output  CNT_W  count of instructions handed to decode.

Behaviour:
- States: REQ, WAIT, HOLD, EXEC, ERR. State after reset is REQ.
- Reset values: cpupc=RESET_PC, inst=0, inst_valid=0, imem_req=0, fetch_err=0, fetch_cnt=0.
  - The first imem_req rises in the cycle after rst deasserts.
- REQ:
  - imem_req=1; imem_addr={cpupc[63:3],3'b0}.
  - Hold imem_req and imem_addr stable until imem_gnt=1, then go to WAIT.
  - If imem_gnt and imem_rvalid arrive in the same cycle, treat it as a grant plus data and go directly to HOLD/ERR per the WAIT rules.
- WAIT:
  - imem_req=0.
  - On imem_rvalid&~imem_rerr: inst <= cpupc[2] ? rdata[63:32] : rdata[31:0]; go to HOLD.
  - On imem_rvalid&imem_rerr: fetch_err <= 1; go to ERR.
- HOLD:
  - inst_valid=1; inst and cpupc stay stable.
  - On inst_ready: fetch_cnt += 1, wrapping at 2^CNT_W; go to EXEC; inst_valid is 0 from the next cycle.
- EXEC:
  - Wait for dnpc_valid.
  - If dnpc[1:0]==0: cpupc <= dnpc; go to REQ.
  - If dnpc[1:0]!=0: fetch_err <= 1; cpupc is unchanged; go to ERR.
- ERR: terminal state. No requests; inst_valid=0. Only rst leaves it.
- dnpc_valid in any state other than EXEC is ignored; cpupc is unchanged.
- imem_rvalid in REQ (no outstanding grant) or in HOLD/EXEC is ignored.
- One outstanding fetch at most; no speculation, no prefetch.
- Latency:
  - Minimum commit-to-valid latency is 2 cycles: REQ with same-cycle gnt+rvalid, then HOLD.
  - Minimum fetch-to-decode latency from REQ is 2 cycles.
- Reset mid-operation (any state, including with a grant outstanding):
  - Return to REQ with reset values.
  - A late imem_rvalid arriving in the first REQ cycle after reset is dropped.
- cpupc must be stable from the HOLD entry until the dnpc_valid commit, so that the next-PC stage sees a constant cpupc+4 / cpupc+imm.

Test Plan:
- Reset then gnt after 1 cycle and rvalid 2 cycles later with rdata=64'h0000_0013_0010_0093 -> imem_addr=64'h8000_0000; inst=32'h0010_0093; inst_valid rises; cpupc=64'h8000_0000.
- Commit with dnpc=64'h8000_0004 -> imem_addr=64'h8000_0000; inst=32'h0000_0013 (upper word); fetch_cnt=2 after accept.
- Decode backpressure: inst_ready held 0 for 5 cycles -> inst_valid and inst stable for all 5 cycles; fetch_cnt increments exactly once on accept.
- dnpc_valid pulsed in HOLD with dnpc=64'h8000_1000 -> ignored; cpupc unchanged; the later EXEC commit with 64'h8000_0100 fetches 64'h8000_0100.
- Misaligned commit dnpc=64'h8000_0006 -> fetch_err=1; no further imem_req; cpupc retains the old value; rst restores cpupc=RESET_PC and fetch_err=0.
- imem_rerr with rvalid in WAIT -> fetch_err=1, inst_valid stays 0. Separately, rst asserted in WAIT then a stray rvalid in the first post-reset cycle -> data ignored; a fresh request to RESET_PC is issued.
